memref_nport: RTL
=================

# memref_nport

Parametrised multi-port memory model with configurable read latency, a built-in initialisation sequencer and sticky access-error flags. It replaces the single-read/single-write memref pair in kernel testbenches: one instance serves every read and write port of a generated kernel, for both HIR-generated and HLS-generated DUTs. It is synthesisable, so the same model can back a kernel on FPGA.

## Interface
Parameters:
- WIDTH, 32, data width in bits
- SIZE, 64, number of words; need not be a power of two
- ADDR_W, $clog2(SIZE), address width
- NRD, 2, number of read ports (1..4)
- NWR, 1, number of write ports (1..4)
- RD_LATENCY, 1, cycles from the sampled rd_en to rd_valid (1..4)
- INIT_MODE, 2, fill pattern after reset: 0 none, 1 zero, 2 index+1

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset, synchronous, active-high
- rd_en  in  NRD  per-port read request
- rd_addr  in  NRD*ADDR_W  packed read addresses; port p occupies bits [p*ADDR_W +: ADDR_W]
- rd_valid  out  NRD  read data valid
- rd_data  out  NRD*WIDTH  packed read data
- wr_en  in  NWR  per-port write request
- wr_addr  in  NWR*ADDR_W  packed write addresses
- wr_data  in  NWR*WIDTH  packed write data
- ready  out  1  initialisation is complete and accesses are accepted
- err_oob  out  1  sticky flag: an address was >= SIZE
- err_wr_conflict  out  1  sticky flag: two write ports hit the same address in one cycle
- err_early  out  1  sticky flag: an access arrived while ready=0

## Operation
- The FSM has three states: INIT, FILL and RUN.
- rst forces INIT from any state.
- On the first cycle after rst deasserts, INIT moves to FILL if INIT_MODE≠0, otherwise to RUN.
- FILL writes one word per cycle, walking a counter from 0 to SIZE-1:
  - mode 1 writes 0;
  - mode 2 writes counter+1, truncated to WIDTH.
  - After the word at SIZE-1 is written, the FSM moves to RUN.
- ready=1 only in RUN.
- While ready=0, requests are ignored: no write takes effect and no rd_valid is produced. Any rd_en or wr_en asserted while ready=0 sets err_early.
- Reads are read-first. A read and a write to the same address in the same cycle return the old data.
- Writes: if several ports write the same address in one cycle, the highest-index port wins and err_wr_conflict is set.
- Out-of-range address (addr >= SIZE):
  - a write is dropped;
  - a read returns rd_valid=1 with data 0;
  - err_oob is set in both cases.
- The error flags clear only on rst.
- Memory contents are not cleared by rst. With INIT_MODE=0, contents are retained across reset.

## Timing
- Reset values: rd_valid=0, rd_data=0, ready=0, all err_* = 0, fill counter = 0.
- Read latency: a read sampled at edge t produces rd_valid and rd_data after edge t+RD_LATENCY. Both hold for exactly one cycle unless rd_en is asserted again.
- Read ports are fully pipelined: one request per port per cycle, with no back-pressure.
- Write latency: a write sampled at edge t is visible to a read sampled at edge t+1 or later.
- Start-up: INIT_MODE≠0 gives ready=1 at cycle SIZE+1 after rst deasserts; INIT_MODE=0 gives ready=1 at cycle 1.
- Reset mid-operation:
  - rd_valid for all in-flight reads is squashed, and rd_data is zeroed on the next edge;
  - a FILL in progress restarts from address 0.
- rd_data is 0 whenever rd_valid=0.

## Structure
- Shared package memref_pkg holds the init_mode_e enum (INIT_NONE, INIT_ZERO, INIT_INDEX) and the state_e enum (INIT, FILL, RUN). memref_nport uses both.
- Sub-module memref_rd_pipe, one instance per read port: a RD_LATENCY-deep valid/data delay line with synchronous clear.
- The storage array, the write-port priority logic and the FSM live in the top module.

## Test plan
- Init, mode 2: SIZE=64. Reset for 2 cycles, then wait. Required: ready rises exactly 65 cycles after rst falls, and reading address 32 returns 33.
- Pipelined reads: RD_LATENCY=3, NRD=2. Read addresses 0..7 back-to-back on both ports. Required: 8 consecutive rd_valid pulses starting 3 cycles after the first request, with data 1..8.
- Collisions:
  - same-cycle read and write of address 5 with data 0xDEAD: the read returns 6 and a read in the next cycle returns 0xDEAD;
  - NWR=2, both ports write address 9 (0x11 and 0x22): the memory holds 0x22 and err_wr_conflict=1.
- Out-of-range: SIZE=48, ADDR_W=6. Write address 50, then read address 50. Required: rd_valid=1 with data 0, err_oob=1, and no word below 48 is modified.
- Early access and reset mid-operation:
  - asserting wr_en during FILL sets err_early and has no effect on memory;
  - asserting rst with 2 reads in flight gives no rd_valid afterwards and restarts FILL from address 0 (ready after 65 cycles).

Source files
------------

// File: rtl/memref_pkg.sv
// Shared types for the multi-port memory model: init fill pattern and sequencer states.
package memref_pkg;

    typedef enum logic [1:0] {
        INIT_NONE  = 2'd0,
        INIT_ZERO  = 2'd1,
        INIT_INDEX = 2'd2
    } init_mode_e;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_e;

    function automatic logic addr_oob(input logic [31:0] addr, input logic [31:0] size);
        return addr >= size;
    endfunction

endpackage

// File: rtl/memref_rd_pipe.sv
// Read-data delay line: carries one read port's valid/data from the sampling edge to the output.
// Latency: LAT cycles, output registered.
// Backpressure: none; accepts one request per cycle, rst squashes everything in flight.
module memref_rd_pipe #(
    parameter int WIDTH = 32,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    logic [LAT-1:0]            vld_q;
    logic [LAT-1:0][WIDTH-1:0] dat_q;

    // Data is zeroed on entry when not valid so the output is 0 whenever valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            dat_q[0] <= in_vld ? in_dat : '0;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_dat = dat_q[LAT-1];

endmodule

// File: rtl/memref_nport.sv
// Multi-port memory model with init sequencer, read-first semantics and sticky access errors.
// Latency: reads RD_LATENCY cycles; writes visible to reads sampled one edge later.
// Backpressure: none; requests while not ready are dropped and flagged via err_early.
module memref_nport
    import memref_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SIZE       = 64,
    parameter int ADDR_W     = $clog2(SIZE),
    parameter int NRD        = 2,
    parameter int NWR        = 1,
    parameter int RD_LATENCY = 1,
    parameter int INIT_MODE  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0]        rd_valid,
    output logic [NRD*WIDTH-1:0]  rd_data,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*WIDTH-1:0]  wr_data,
    output logic                  ready,
    output logic                  err_oob,
    output logic                  err_wr_conflict,
    output logic                  err_early
);

    localparam init_mode_e        MODE = init_mode_e'(INIT_MODE);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fill_cnt_q;
    logic [WIDTH-1:0]  fill_word;
    logic [WIDTH-1:0]  mem [SIZE];

    logic [NRD-1:0]    rd_req, rd_oob;
    logic [NWR-1:0]    wr_req, wr_oob;
    logic [ADDR_W-1:0] wa [NWR];
    logic [WIDTH-1:0]  wd [NWR];
    logic              wr_conflict;

    assign ready  = (state_q == RUN);
    assign rd_req = rd_en & {NRD{ready}};

    always_comb begin
        state_d   = state_q;
        fill_word = '0;
        case (state_q)
            INIT:    state_d = (MODE == INIT_NONE) ? RUN : FILL;
            FILL:    if (fill_cnt_q == LAST) state_d = RUN;
            default: state_d = state_q;
        endcase
        if (MODE == INIT_INDEX) fill_word = WIDTH'(32'(fill_cnt_q) + 32'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            fill_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FILL) fill_cnt_q <= fill_cnt_q + ADDR_W'(1);
        end
    end

    always_comb begin
        wr_conflict = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            wa[p]     = wr_addr[p*ADDR_W +: ADDR_W];
            wd[p]     = wr_data[p*WIDTH +: WIDTH];
            wr_oob[p] = addr_oob(32'(wa[p]), 32'(SIZE));
            wr_req[p] = wr_en[p] && ready;
        end
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (wr_req[i] && wr_req[j] && (wa[i] == wa[j])) wr_conflict = 1'b1;
            end
        end
    end

    // Storage deliberately has no reset so contents survive rst when INIT_MODE is 0.
    // Ascending loop order makes the highest-index write port win a collision.
    always_ff @(posedge clk) begin
        if (state_q == FILL) mem[fill_cnt_q] <= fill_word;
        for (int p = 0; p < NWR; p++) begin
            if (wr_req[p] && !wr_oob[p]) mem[wa[p]] <= wd[p];
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [WIDTH-1:0]  word;

        assign ra        = rd_addr[g*ADDR_W +: ADDR_W];
        assign rd_oob[g] = addr_oob(32'(ra), 32'(SIZE));
        assign word      = rd_oob[g] ? '0 : mem[ra];

        memref_rd_pipe #(
            .WIDTH (WIDTH),
            .LAT   (RD_LATENCY)
        ) u_pipe (
            .clk     (clk),
            .rst     (rst),
            .in_vld  (rd_req[g]),
            .in_dat  (word),
            .out_vld (rd_valid[g]),
            .out_dat (rd_data[g*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_oob         <= 1'b0;
            err_wr_conflict <= 1'b0;
            err_early       <= 1'b0;
        end else begin
            if (|(wr_req & wr_oob) || |(rd_req & rd_oob)) err_oob <= 1'b1;
            if (wr_conflict) err_wr_conflict <= 1'b1;
            if (!ready && (|rd_en || |wr_en)) err_early <= 1'b1;
        end
    end

endmodule
